// File: rtl/mul_div_unit_pkg.sv
// rtl/mul_div_unit_pkg.sv - shared op encodings, FSM states and helpers for the HI/LO multiply/divide unit.
package mul_div_unit_pkg;

  localparam int ITER_CYCLES_DEFAULT = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - EX-stage request and HI/LO result bundle of the multiply/divide unit.
interface mul_div_unit_if;

  logic        i_start;
  logic [1:0]  i_op;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        i_flush;
  logic        i_mthi;
  logic        i_mtlo;
  logic [31:0] o_hi;
  logic [31:0] o_lo;
  logic        o_busy;
  logic        o_done;

  modport slave (
    input  i_start, i_op, i_a, i_b, i_flush, i_mthi, i_mtlo,
    output o_hi, o_lo, o_busy, o_done
  );

  modport master (
    output i_start, i_op, i_a, i_b, i_flush, i_mthi, i_mtlo,
    input  o_hi, o_lo, o_busy, o_done
  );

endinterface

// File: rtl/mul_div_unit_div_step.sv
// rtl/mul_div_unit_div_step.sv - one unsigned restoring-division step: shift in a dividend bit, trial subtract.
module div_step (
  input  logic [31:0] i_rem,
  input  logic        i_msb,
  input  logic [31:0] i_divisor,
  output logic [31:0] o_rem,
  output logic        o_qbit
);

  logic [32:0] w_shift;
  logic [32:0] w_diff;

  // The partial remainder is always below the divisor, so a clear bit 32 means the trial fits.
  assign w_shift = {i_rem, i_msb};
  assign w_diff  = w_shift - {1'b0, i_divisor};
  assign o_qbit  = ~w_diff[32];
  assign o_rem   = o_qbit ? w_diff[31:0] : w_shift[31:0];

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative radix-2 mult/multu/div/divu unit owning the architectural HI/LO registers.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int ITER_CYCLES = ITER_CYCLES_DEFAULT
) (
  input  logic           i_clk,
  input  logic           i_rst,
  mul_div_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(ITER_CYCLES + 1);

  state_e             r_state;
  state_e             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div;
  logic               r_neg_lo;
  logic               r_neg_hi;
  logic [31:0]        r_rem;
  logic [31:0]        r_quo;
  logic [31:0]        r_b;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;

  logic               w_accept;
  logic               w_last;
  logic               w_signed;
  logic               w_sa;
  logic               w_sb;
  logic [32:0]        w_sum;
  logic [31:0]        w_div_rem;
  logic               w_qbit;
  logic               w_hi_cin;
  logic [31:0]        w_hi_fix;
  logic [31:0]        w_lo_fix;

  assign w_accept = (r_state == ST_IDLE) && bus.i_start && !bus.i_flush;
  assign w_last   = (r_cnt == CNT_W'(ITER_CYCLES - 1));
  assign w_signed = ~bus.i_op[0];
  assign w_sa     = w_signed & bus.i_a[31];
  assign w_sb     = w_signed & bus.i_b[31];

  // Multiply: r_rem:r_quo is the product register, multiplier consumed from r_quo's LSB.
  assign w_sum = r_quo[0] ? ({1'b0, r_rem} + {1'b0, r_b}) : {1'b0, r_rem};

  div_step u_div_step (
    .i_rem     (r_rem),
    .i_msb     (r_quo[31]),
    .i_divisor (r_b),
    .o_rem     (w_div_rem),
    .o_qbit    (w_qbit)
  );

  // Shared negation: for mult HI receives the borrow out of LO, for div HI negates on its own.
  assign w_lo_fix = r_neg_lo ? (~r_quo + 32'd1) : r_quo;
  assign w_hi_cin = r_is_div ? 1'b1 : (r_quo == 32'd0);
  assign w_hi_fix = r_neg_hi ? (~r_rem + {31'd0, w_hi_cin}) : r_rem;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_CALC;
      ST_CALC: if (w_last)   w_next = ST_FIX;
      ST_FIX:                w_next = ST_IDLE;
      default:               w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_rem    <= 32'd0;
      r_quo    <= 32'd0;
      r_b      <= 32'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_cnt    <= '0;
            r_is_div <= bus.i_op[1];
            r_rem    <= 32'd0;
            r_quo    <= mag32(bus.i_a, w_signed);
            r_b      <= mag32(bus.i_b, w_signed);
            // A zero divisor keeps the all-ones quotient and restores HI to the raw dividend.
            r_neg_lo <= bus.i_op[1] ? ((w_sa ^ w_sb) & (bus.i_b != 32'd0)) : (w_sa ^ w_sb);
            r_neg_hi <= bus.i_op[1] ? w_sa : (w_sa ^ w_sb);
          end else if (!bus.i_start) begin
            if (bus.i_mthi) r_hi <= bus.i_a;
            if (bus.i_mtlo) r_lo <= bus.i_a;
          end
        end
        ST_CALC: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_is_div) begin
            r_rem <= w_div_rem;
            r_quo <= {r_quo[30:0], w_qbit};
          end else begin
            r_rem <= w_sum[32:1];
            r_quo <= {w_sum[0], r_quo[31:1]};
          end
        end
        ST_FIX: begin
          r_hi <= w_hi_fix;
          r_lo <= w_lo_fix;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_hi   = r_hi;
  assign bus.o_lo   = r_lo;
  assign bus.o_busy = (bus.i_start && !i_rst) || (r_state != ST_IDLE);
  assign bus.o_done = (r_state == ST_FIX) && !i_rst;

endmodule
